// File: rtl/out_vc_state.sv
// out_vc_state
//   Per-output-port tracker of downstream virtual-channel state. It claims
//   output VCs on allocator grants, counts flit departures against credit
//   returns per VC, and releases a VC only after its tail has left and every
//   downstream buffer slot has been credited back (atomic VC reallocation).
//
// Ports
//   clk                  sole clock, rising edge
//   rstn                 synchronous reset, active-high (1 clears state)
//   outVCAvailableReset  [CN] per-VC allocation pulse from the VC allocator
//   flitSent             [CN] one-hot/zero, flit leaving on VC v this cycle
//   tailSent             [CN] qualifies flitSent: that flit is a tail
//   creditIn             [CN] per-VC credit return from downstream
//   outVCAvailable       [CN] bit v = 1 when VC v is IDLE
//   creditAvailable      [CN] bit v = 1 when VC v has a nonzero credit count
//   protocolErr          sticky protocol-violation flag, cleared by reset
module out_vc_state #(
  parameter int CN    = 6,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [CN-1:0] outVCAvailableReset,
  input  logic [CN-1:0] flitSent,
  input  logic [CN-1:0] tailSent,
  input  logic [CN-1:0] creditIn,
  output logic [CN-1:0] outVCAvailable,
  output logic [CN-1:0] creditAvailable,
  output logic          protocolErr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } vc_state_e;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  vc_state_e     state_q [CN];
  vc_state_e     state_d [CN];
  logic [CW-1:0] cnt_q   [CN];
  logic [CW-1:0] cnt_d   [CN];
  logic          err_q;
  logic          err_d;
  logic [CN-1:0] send_counted;
  logic          multi_send;

  // More than one departure in a cycle is illegal on a single output port.
  assign multi_send = (flitSent & (flitSent - CN'(1))) != '0;

  always_comb begin
    err_d        = err_q;
    send_counted = '0;
    for (int unsigned v = 0; v < CN; v++) begin
      state_d[v] = state_q[v];
      cnt_d[v]   = cnt_q[v];
    end

    if (multi_send) begin
      err_d = 1'b1;
    end

    for (int unsigned v = 0; v < CN; v++) begin
      // A flit on an IDLE VC (including one racing its own allocation) is
      // never counted against credits.
      send_counted[v] = flitSent[v] && (state_q[v] != IDLE);

      if (tailSent[v] && !flitSent[v]) begin
        err_d = 1'b1;
      end
      if (flitSent[v] && (state_q[v] == IDLE)) begin
        err_d = 1'b1;
      end
      if (outVCAvailableReset[v] && (state_q[v] != IDLE)) begin
        err_d = 1'b1;
      end

      // Send and credit together cancel; an update that would leave the
      // range [0, DEPTH] is dropped and flagged.
      if (send_counted[v] && !creditIn[v]) begin
        if (cnt_q[v] == '0) begin
          err_d = 1'b1;
        end else begin
          cnt_d[v] = cnt_q[v] - CW'(1);
        end
      end else if (creditIn[v] && !send_counted[v]) begin
        if (cnt_q[v] == FULL) begin
          err_d = 1'b1;
        end else begin
          cnt_d[v] = cnt_q[v] + CW'(1);
        end
      end

      unique case (state_q[v])
        IDLE: begin
          if (outVCAvailableReset[v]) begin
            state_d[v] = ACTIVE;
          end
        end
        ACTIVE: begin
          if (send_counted[v] && tailSent[v]) begin
            state_d[v] = DRAIN;
          end
        end
        DRAIN: begin
          // Release is judged on the post-update count so the VC frees in
          // the cycle right after its last credit lands.
          if (cnt_d[v] == FULL) begin
            state_d[v] = IDLE;
          end
        end
        default: begin
          state_d[v] = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int unsigned v = 0; v < CN; v++) begin
        state_q[v] <= IDLE;
        cnt_q[v]   <= FULL;
      end
      err_q <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < CN; v++) begin
        state_q[v] <= state_d[v];
        cnt_q[v]   <= cnt_d[v];
      end
      err_q <= err_d;
    end
  end

  always_comb begin
    outVCAvailable  = '0;
    creditAvailable = '0;
    for (int unsigned v = 0; v < CN; v++) begin
      outVCAvailable[v]  = (state_q[v] == IDLE);
      creditAvailable[v] = (cnt_q[v] != '0);
    end
  end

  assign protocolErr = err_q;

endmodule

// File: doc/out_vc_state.md
# out_vc_state

Per-output-port tracker of downstream virtual-channel state in the mesh router, sitting on the far side of the VC allocator. Allocation pulses come in from the allocator and are used to claim output VCs. Flit departures and credit returns are counted per VC. The block produces the `outVCAvailable` vector the allocator masks requests with, plus a per-VC credit-available vector for switch allocation. A VC is released only after its tail has left and every downstream buffer slot has been credited back (atomic VC reallocation).

## Interface
- `CN`, default 6: number of VCs per port; matches the global `CN` define.
- `DEPTH`, default 4: downstream input-buffer depth per VC, in flits.
- `CW`, default `$clog2(DEPTH+1)`: credit counter width.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rstn`  in  1  reset; synchronous, active-high (asserted = 1 clears state on the next `clk` edge).
- `outVCAvailableReset`  in  CN  per-VC allocation pulse from the VC allocator; bit v high means output VC v was granted this cycle.
- `flitSent`  in  CN  one-hot or zero; bit v means a flit leaves on output VC v this cycle.
- `tailSent`  in  CN  qualifies `flitSent`; bit v means that flit is a tail (a single-flit packet asserts both).
- `creditIn`  in  CN  per-VC credit return from downstream; any combination of bits may be set.
- `outVCAvailable`  out  CN  registered; bit v = 1 when VC v is IDLE.
- `creditAvailable`  out  CN  bit v = 1 when credit count of v is nonzero; decoded from registers only.
- `protocolErr`  out  1  sticky error flag, cleared only by reset.

## Operation
- Each VC v has a 2-bit state (IDLE, ACTIVE, DRAIN) and a `CW`-bit credit counter `cnt[v]`.
- Transitions:
  - IDLE → ACTIVE on `outVCAvailableReset[v]`.
  - ACTIVE → DRAIN on `flitSent[v] & tailSent[v]`.
  - DRAIN → IDLE when the next value of `cnt[v]` equals `DEPTH`.
  - All other combinations hold state.
- Credit arithmetic, `cnt_next = cnt - flitSent[v] + creditIn[v]`:
  - Simultaneous send and credit leaves `cnt` unchanged.
  - `cnt` is never allowed below 0 or above `DEPTH`; the offending update is dropped and the counter holds.
- Error conditions. Each sets `protocolErr`; state is left unchanged except where noted.
  - `outVCAvailableReset[v]` while VC v is not IDLE: the pulse is ignored.
  - `flitSent[v]` while IDLE.
  - `flitSent[v]` with `cnt[v] == 0`: the decrement is dropped.
  - `creditIn[v]` with `cnt[v] == DEPTH`: the increment is dropped.
  - `flitSent` with more than one bit set.
  - `tailSent[v]` without `flitSent[v]`.
- `outVCAvailableReset[v]` and `flitSent[v]` in the same cycle while IDLE:
  - This is an error; the allocation is still taken (→ ACTIVE).
  - The flit is ignored for counting.
- `tailSent` on a non-tail flit in ACTIVE keeps the VC ACTIVE and decrements `cnt` normally.
- VCs are fully independent; no cross-VC arbitration exists in this block.

## Timing
- Reset values:
  - All VCs IDLE, so `outVCAvailable` = all ones.
  - `cnt` = `DEPTH` for every VC, so `creditAvailable` = all ones.
  - `protocolErr` = 0.
- Allocation latency:
  - A pulse in cycle t drops `outVCAvailable[v]` in cycle t+1.
  - The allocator therefore cannot regrant v in t+1.
  - The first flit may be sent in t+1.
- Credit latency:
  - A send or credit in cycle t is reflected in `cnt` and `creditAvailable` in cycle t+1.
  - There is no combinational path from any input to any output.
- Release latency:
  - If the last credit arrives in cycle t (DRAIN), `outVCAvailable[v]` rises in t+1.
  - A tail sent in cycle t with no credits outstanding beforehand gives: DRAIN in t+1; the earliest IDLE is the cycle after the credit for that flit returns.
- Reset asserted mid-packet discards all state in one cycle; inputs sampled in that cycle are ignored.

## Test plan
- Reset release then idle 5 cycles → `outVCAvailable` = 6'b111111, `creditAvailable` = 6'b111111, `protocolErr` = 0.
- Alloc VC2 at t; send 4 flits (t+1..t+4, tail at t+4); no credits → `outVCAvailable[2]` = 0 from t+1; `creditAvailable[2]` = 0 at t+5; state DRAIN.
- Continue the previous case: return 4 credits, one per cycle, at t+6..t+9 → `outVCAvailable[2]` = 1 at t+10 and not earlier; cnt = 4.
- Single-flit packet on VC0: alloc at t; head+tail at t+1 with `creditIn[0]` in the same cycle → cnt stays 4, DRAIN at t+2, IDLE at t+3; `protocolErr` = 0.
- Allocate VC1 and VC4 in the same cycle; interleave flits; send with cnt = 0 on VC1 → both `outVCAvailable` bits clear next cycle; illegal send sets `protocolErr` = 1, cnt stays 0, VC4 unaffected.
- Credit to IDLE VC5 with cnt = 4; then assert `rstn` mid-packet on VC3 → `protocolErr` = 1 and cnt[5] = 4; after reset all outputs return to reset values.
